// File: rtl/pong_pkg.sv
// Shared definitions for the pong game stages: FSM state encoding, winner
// codes, default board geometry and a saturating score helper.
package pong_pkg;

    localparam int COORD_W = 6;            // ball/paddle coordinate width
    localparam int SPAN_W  = COORD_W + 1;  // paddle span math is one bit wider
    localparam int SCORE_W = 4;

    localparam int DEF_BOARD_WIDTH   = 40;
    localparam int DEF_BOARD_HEIGHT  = 30;
    localparam int DEF_PADDLE_HEIGHT = 6;
    localparam int DEF_SCORE_LIMIT   = 9;
    localparam int DEF_PAUSE_CYCLES  = 25000000;

    typedef enum logic [1:0] {
        ST_IDLE      = 2'd0,
        ST_RUNNING   = 2'd1,
        ST_POINT     = 2'd2,
        ST_GAME_OVER = 2'd3
    } game_state_e;

    typedef enum logic [1:0] {
        WIN_NONE = 2'b00,
        WIN_P1   = 2'b01,
        WIN_P2   = 2'b10
    } winner_e;

    // Increment a score but never beyond the limit.
    function automatic logic [SCORE_W-1:0] sat_inc(input logic [SCORE_W-1:0] score,
                                                   input logic [SCORE_W-1:0] limit);
        return (score < limit) ? score + SCORE_W'(1) : score;
    endfunction

endpackage

// File: rtl/pong_paddle_hit.sv
// Combinational paddle coverage test: is the ball row inside the paddle span?
// The span bottom is formed one bit wider than the coordinates so a paddle
// near the bottom edge never wraps back to the top.
module pong_paddle_hit
    import pong_pkg::*;
#(
    parameter int PADDLE_HEIGHT = DEF_PADDLE_HEIGHT
) (
    input  logic [COORD_W-1:0] i_paddle_y,
    input  logic [COORD_W-1:0] i_ball_y,
    output logic               o_hit
);

    logic [SPAN_W-1:0] span_bottom;

    assign span_bottom = {1'b0, i_paddle_y} + SPAN_W'(PADDLE_HEIGHT - 1);
    assign o_hit       = (i_ball_y >= i_paddle_y) && ({1'b0, i_ball_y} <= span_bottom);

endmodule

// File: rtl/pong_game_ctrl.sv
// Pong game-level controller: start-button edge detect, miss detection at the
// goal columns, saturating per-player scores and the
// idle -> running -> point -> game-over sequence that gates the ball stage.
// Optional build macro: PONG_SERVE_ALTERNATE_EN adds o_serve_dir, which aims
// the next serve at the player who just conceded a point.
module pong_game_ctrl
    import pong_pkg::*;
#(
    parameter int BOARD_WIDTH   = DEF_BOARD_WIDTH,
    parameter int BOARD_HEIGHT  = DEF_BOARD_HEIGHT,
    parameter int PADDLE_HEIGHT = DEF_PADDLE_HEIGHT,
    parameter int SCORE_LIMIT   = DEF_SCORE_LIMIT,
    parameter int PAUSE_CYCLES  = DEF_PAUSE_CYCLES
) (
    input  logic               clk,
    input  logic               i_rst_n,
    input  logic               i_start_btn,
    input  logic [COORD_W-1:0] i_ball_x,
    input  logic [COORD_W-1:0] i_ball_y,
    input  logic [COORD_W-1:0] i_paddle_y1,
    input  logic [COORD_W-1:0] i_paddle_y2,
    output logic               o_game_active,
    output logic [SCORE_W-1:0] o_score_p1,
    output logic [SCORE_W-1:0] o_score_p2,
    output logic               o_game_over,
    output logic [1:0]         o_winner
`ifdef PONG_SERVE_ALTERNATE_EN
    ,
    output logic               o_serve_dir
`endif
);

    localparam int                 PAUSE_W    = (PAUSE_CYCLES > 1) ? $clog2(PAUSE_CYCLES) : 1;
    localparam logic [PAUSE_W-1:0] PAUSE_LAST = PAUSE_W'(PAUSE_CYCLES - 1);
    localparam logic [COORD_W-1:0] RIGHT_COL  = COORD_W'(BOARD_WIDTH - 1);
    localparam logic [SCORE_W-1:0] LIMIT      = SCORE_W'(SCORE_LIMIT);

    // Coordinates are 6 bits, so the board must fit in 64x64 cells.
    if (BOARD_WIDTH < 1 || BOARD_WIDTH > 64 || BOARD_HEIGHT < 1 || BOARD_HEIGHT > 64 ||
        PADDLE_HEIGHT < 1 || SCORE_LIMIT < 1 || SCORE_LIMIT > 15 || PAUSE_CYCLES < 1)
    begin : g_bad_params
        $error("pong_game_ctrl: parameter out of range");
    end

    game_state_e        state_q;
    winner_e            winner_q;
    logic [SCORE_W-1:0] score_p1_q, score_p2_q;
    logic [PAUSE_W-1:0] pause_q;
    logic               active_q, over_q;
    logic               btn_s1_q, btn_s2_q;

    logic               start_press;
    logic               hit_p1, hit_p2;
    logic               miss_left, miss_right;
    logic [SCORE_W-1:0] score_p1_d, score_p2_d;

    pong_paddle_hit #(.PADDLE_HEIGHT(PADDLE_HEIGHT)) u_hit_p1 (
        .i_paddle_y (i_paddle_y1),
        .i_ball_y   (i_ball_y),
        .o_hit      (hit_p1)
    );

    pong_paddle_hit #(.PADDLE_HEIGHT(PADDLE_HEIGHT)) u_hit_p2 (
        .i_paddle_y (i_paddle_y2),
        .i_ball_y   (i_ball_y),
        .o_hit      (hit_p2)
    );

    // Register the button and remember its previous sample for edge detection.
    // NOTE: state registers use non-blocking assignments so every flop samples
    // pre-edge values regardless of block evaluation order.
    always_ff @(posedge clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            btn_s1_q <= 1'b0;
            btn_s2_q <= 1'b0;
        end else begin
            btn_s1_q <= i_start_btn;
            btn_s2_q <= btn_s1_q;
        end
    end

    // A press is a single 0->1 transition; a held button stays at 1/1.
    assign start_press = btn_s1_q & ~btn_s2_q;

    // Misses only count while the ball is in play; left wins a tie.
    assign miss_left  = (state_q == ST_RUNNING) && (i_ball_x == '0) && !hit_p1;
    assign miss_right = (state_q == ST_RUNNING) && (i_ball_x == RIGHT_COL) && !hit_p2 && !miss_left;

    // A left miss is a point for P2, a right miss a point for P1.
    assign score_p1_d = sat_inc(score_p1_q, LIMIT);
    assign score_p2_d = sat_inc(score_p2_q, LIMIT);

    // Game sequencer with registered outputs.
    always_ff @(posedge clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q    <= ST_IDLE;
            score_p1_q <= '0;
            score_p2_q <= '0;
            pause_q    <= '0;
            active_q   <= 1'b0;
            over_q     <= 1'b0;
            winner_q   <= WIN_NONE;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (start_press) begin
                        score_p1_q <= '0;
                        score_p2_q <= '0;
                        active_q   <= 1'b1;
                        state_q    <= ST_RUNNING;
                    end
                end
                ST_RUNNING: begin
                    if (miss_left) begin
                        score_p2_q <= score_p2_d;
                        active_q   <= 1'b0;
                        pause_q    <= '0;
                        if (score_p2_d == LIMIT) begin
                            over_q   <= 1'b1;
                            winner_q <= WIN_P2;
                            state_q  <= ST_GAME_OVER;
                        end else begin
                            state_q  <= ST_POINT;
                        end
                    end else if (miss_right) begin
                        score_p1_q <= score_p1_d;
                        active_q   <= 1'b0;
                        pause_q    <= '0;
                        if (score_p1_d == LIMIT) begin
                            over_q   <= 1'b1;
                            winner_q <= WIN_P1;
                            state_q  <= ST_GAME_OVER;
                        end else begin
                            state_q  <= ST_POINT;
                        end
                    end
                end
                ST_POINT: begin
                    if (pause_q == PAUSE_LAST) begin
                        pause_q  <= '0;
                        active_q <= 1'b1;
                        state_q  <= ST_RUNNING;
                    end else begin
                        pause_q  <= pause_q + PAUSE_W'(1);
                    end
                end
                ST_GAME_OVER: begin
                    if (start_press) begin
                        score_p1_q <= '0;
                        score_p2_q <= '0;
                        winner_q   <= WIN_NONE;
                        over_q     <= 1'b0;
                        active_q   <= 1'b1;
                        state_q    <= ST_RUNNING;
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign o_game_active = active_q;
    assign o_score_p1    = score_p1_q;
    assign o_score_p2    = score_p2_q;
    assign o_game_over   = over_q;
    assign o_winner      = winner_q;

`ifdef PONG_SERVE_ALTERNATE_EN
    logic serve_q;

    // Aim the next serve at whoever conceded the last point; frozen during play.
    always_ff @(posedge clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            serve_q <= 1'b0;
        end else if (miss_left) begin
            serve_q <= 1'b0;
        end else if (miss_right) begin
            serve_q <= 1'b1;
        end
    end

    assign o_serve_dir = serve_q;
`endif

endmodule

// File: tb/tb_pong_game_ctrl.sv
// Self-checking bench for pong_game_ctrl: directed scenarios with literal
// expectations, then randomized play compared every cycle against a
// behavioural game model. Honours PONG_SERVE_ALTERNATE_EN when defined.
module tb_pong_game_ctrl;

    localparam int W     = 40;
    localparam int H     = 30;
    localparam int PH    = 6;
    localparam int LIM   = 3;
    localparam int PAUSE = 8;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       btn;
    logic [5:0] bx, by, py1, py2;
    logic       act, over;
    logic [3:0] s1, s2;
    logic [1:0] win;
`ifdef PONG_SERVE_ALTERNATE_EN
    logic       serve;
`endif

    pong_game_ctrl #(
        .BOARD_WIDTH   (W),
        .BOARD_HEIGHT  (H),
        .PADDLE_HEIGHT (PH),
        .SCORE_LIMIT   (LIM),
        .PAUSE_CYCLES  (PAUSE)
    ) dut (
        .clk           (clk),
        .i_rst_n       (rst_n),
        .i_start_btn   (btn),
        .i_ball_x      (bx),
        .i_ball_y      (by),
        .i_paddle_y1   (py1),
        .i_paddle_y2   (py2),
        .o_game_active (act),
        .o_score_p1    (s1),
        .o_score_p2    (s2),
        .o_game_over   (over),
        .o_winner      (win)
`ifdef PONG_SERVE_ALTERNATE_EN
        ,
        .o_serve_dir   (serve)
`endif
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, got, exp, $time);
        end
    endtask

    // ---------------- behavioural game model ----------------
    bit m_play, m_pause, m_over;    // none set means idle
    int m_p1, m_p2, m_left, m_winner, m_serve;
    bit m_seen1, m_seen2;           // button seen at the last two edges

    function automatic bit covered(input int paddle_top, input int ball_row);
        return (ball_row >= paddle_top) && (ball_row <= paddle_top + PH - 1);
    endfunction

    initial begin
        forever begin
            @(posedge clk or negedge rst_n);
            if (!rst_n) begin
                m_play = 0; m_pause = 0; m_over = 0;
                m_p1 = 0; m_p2 = 0; m_left = 0; m_winner = 0; m_serve = 0;
                m_seen1 = 0; m_seen2 = 0;
            end else begin
                bit press;
                bit lmiss, rmiss;
                // A press takes effect two edges after the button is first seen high.
                press   = m_seen1 && !m_seen2;
                m_seen2 = m_seen1;
                m_seen1 = btn;
                lmiss = m_play && (int'(bx) == 0) && !covered(int'(py1), int'(by));
                rmiss = m_play && !lmiss && (int'(bx) == W - 1) && !covered(int'(py2), int'(by));
                if (!m_play && !m_pause && !m_over) begin
                    if (press) begin m_play = 1; m_p1 = 0; m_p2 = 0; end
                end else if (m_over) begin
                    if (press) begin m_over = 0; m_play = 1; m_p1 = 0; m_p2 = 0; m_winner = 0; end
                end else if (m_pause) begin
                    m_left--;
                    if (m_left == 0) begin m_pause = 0; m_play = 1; end
                end else if (lmiss || rmiss) begin
                    m_play  = 0;
                    m_serve = lmiss ? 0 : 1;
                    if (lmiss) m_p2 = (m_p2 < LIM) ? m_p2 + 1 : m_p2;
                    else       m_p1 = (m_p1 < LIM) ? m_p1 + 1 : m_p1;
                    if (m_p1 == LIM || m_p2 == LIM) begin
                        m_over   = 1;
                        m_winner = (m_p2 == LIM) ? 2 : 1;
                    end else begin
                        m_pause = 1;
                        m_left  = PAUSE;
                    end
                end
            end
        end
    end

    // Per-cycle comparison of every output against the model.
    bit cmp_en = 0;
    always @(negedge clk) begin
        if (cmp_en && rst_n) begin
            check("model_active", 32'(act),  32'(m_play));
            check("model_p1",     32'(s1),   32'(m_p1));
            check("model_p2",     32'(s2),   32'(m_p2));
            check("model_over",   32'(over), 32'(m_over));
            check("model_winner", 32'(win),  32'(m_winner));
`ifdef PONG_SERVE_ALTERNATE_EN
            check("model_serve",  32'(serve), 32'(m_serve));
`endif
        end
    end

    // ---------------- stimulus helpers ----------------
    // Advance n cycles; inputs are driven just after the falling edge.
    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
        #1;
    endtask

    task automatic ball(input int x, input int y);
        bx = 6'(x);
        by = 6'(y);
    endtask

    // Wait out a pause (ball parked mid-board); returns the low cycle count.
    task automatic wait_pause(output int low);
        low = 0;
        while (act == 1'b0 && low < 100) begin
            low++;
            cyc(1);
        end
    endtask

    task automatic press_start;
        btn = 1'b1;
        cyc(2);
    endtask

    int low;

    initial begin
        rst_n = 1'b0; btn = 1'b0;
        bx = 6'd20; by = 6'd5; py1 = 6'd10; py2 = 6'd27;
        #23;
        // Test 1: reset values, then start press latency.
        check("rst_active", 32'(act), 0);
        check("rst_scores", 32'({s1, s2}), 0);
        check("rst_over",   32'(over), 0);
        check("rst_winner", 32'(win), 0);
        cyc(1);
        rst_n  = 1'b1;
        cmp_en = 1'b1;
        cyc(2);
        btn = 1'b1;
        cyc(1);
        check("start_1st_clk", 32'(act), 0);
        cyc(1);
        check("start_2nd_clk", 32'(act), 1);
        check("start_scores",  32'({s1, s2}), 0);
        btn = 1'b0;

        // Test 2: hit on paddle 1, then a left miss and the pause length.
        ball(0, 12);
        cyc(3);
        check("p1_hit_score", 32'(s2), 0);
        check("p1_hit_active", 32'(act), 1);
        ball(0, 16);
        cyc(1);
        check("lmiss_score_p2", 32'(s2), 1);
        check("lmiss_active",   32'(act), 0);
`ifdef PONG_SERVE_ALTERNATE_EN
        check("serve_after_p1_miss", 32'(serve), 0);
`endif
        ball(20, 16);
        wait_pause(low);
        check("pause_length", 32'(low), PAUSE);
        check("pause_resume", 32'(act), 1);

        // Test 3: paddle 2 near the bottom edge, no wrap; then a right miss.
        ball(39, 31);
        cyc(2);
        check("p2_hit_y31", 32'(s1), 0);
        ball(39, 29);
        cyc(2);
        check("p2_hit_y29", 32'(s1), 0);
        check("p2_hit_active", 32'(act), 1);
        ball(39, 20);
        cyc(1);
        check("rmiss_score_p1", 32'(s1), 1);
        check("rmiss_active",   32'(act), 0);
`ifdef PONG_SERVE_ALTERNATE_EN
        check("serve_after_p2_miss", 32'(serve), 1);
`endif
        ball(20, 20);
        wait_pause(low);
        check("pause_length2", 32'(low), PAUSE);

        // Test 5: asynchronous reset in the middle of a pause at 2/1.
        ball(39, 20);
        cyc(1);
        ball(20, 20);
        cyc(3);
        check("pre_reset_p1", 32'(s1), 2);
        check("pre_reset_p2", 32'(s2), 1);
        rst_n = 1'b0;
        #1;
        check("async_rst_scores", 32'({s1, s2}), 0);
        check("async_rst_active", 32'(act), 0);
        check("async_rst_over",   32'({over, win}), 0);
        cyc(2);
        rst_n = 1'b1;
        cyc(1);

        // Test 4: play to the limit with the button held throughout.
        press_start;
        check("restart_active", 32'(act), 1);
        for (int i = 0; i < LIM; i++) begin
            ball(0, 40);
            cyc(1);
            ball(20, 5);
            if (i < LIM - 1) begin
                wait_pause(low);
                check("limit_pause", 32'(low), PAUSE);
            end
        end
        check("over_p2",     32'(s2), 3);
        check("over_flag",   32'(over), 1);
        check("over_winner", 32'(win), 2);
        check("over_active", 32'(act), 0);
        cyc(6);
        check("held_no_restart", 32'(over), 1);
        btn = 1'b0;
        cyc(2);
        press_start;
        check("new_game_scores", 32'({s1, s2}), 0);
        check("new_game_active", 32'(act), 1);
        check("new_game_winner", 32'({over, win}), 0);

        // Randomized play, compared every cycle against the model.
        for (int n = 0; n < 4000; n++) begin
            int r;
            r = int'($urandom_range(0, 3));
            if (r == 0)      bx = 6'd0;
            else if (r == 1) bx = 6'(W - 1);
            else             bx = 6'($urandom_range(1, W - 2));
            by = 6'($urandom_range(0, 63));
            if ($urandom_range(0, 7) == 0) py1 = 6'($urandom_range(0, 63));
            if ($urandom_range(0, 7) == 0) py2 = 6'($urandom_range(0, 63));
            if ($urandom_range(0, 5) == 0) btn = ~btn;
            if ($urandom_range(0, 799) == 0) begin
                rst_n = 1'b0;
                cyc(1);
                rst_n = 1'b1;
            end
            cyc(1);
        end

        cmp_en = 1'b0;
        @(posedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/pong_game_ctrl.md
Name: pong_game_ctrl

Overview:
Game-level controller that sits directly downstream of the ball stage and feeds its start input. It watches ball and paddle positions in board-cell units, detects missed balls at the left/right edges, and keeps per-player scores. It drives the ball stage's start/active line: low holds the ball at centre, high lets it move. It also runs the idle → serve → play → point → game-over sequence.

Parameters:
BOARD_WIDTH, 40, board width in cells; right goal column is BOARD_WIDTH-1
BOARD_HEIGHT, 30, board height in cells (range checks only)
PADDLE_HEIGHT, 6, paddle length in cells, measured downward from paddle top y
SCORE_LIMIT, 9, points needed to win (1..15)
PAUSE_CYCLES, 25000000, clk cycles the ball is held at centre after a point

Ports:
clk  in  1  system clock
i_rst_n  in  1  reset; asynchronous assert, active-low
i_start_btn  in  1  start button, level, already synchronised/debounced
i_ball_x  in  6  current ball column from ball stage
i_ball_y  in  6  current ball row from ball stage
i_paddle_y1  in  6  left paddle top row
i_paddle_y2  in  6  right paddle top row
o_game_active  out  1  drives ball stage start input; 0 = hold ball at centre
o_score_p1  out  4  left player score
o_score_p2  out  4  right player score
o_game_over  out  1  high while in GAME_OVER
o_winner  out  2  00 none, 01 P1, 10 P2; valid while o_game_over=1

Behaviour:
- Reset (async, i_rst_n=0): state IDLE; all outputs 0; pause counter 0; start-edge register 0.
- Start press is the rising edge of i_start_btn (one registered stage). A held button never counts as a second press.
- FSM states and transitions:
  - IDLE: start press → clear both scores, go to RUNNING next cycle.
  - RUNNING: o_game_active=1.
  - POINT: o_game_active=0; pause counter counts 0..PAUSE_CYCLES-1, then go to RUNNING.
  - GAME_OVER: o_game_active=0, o_game_over=1, o_winner set; start press → clear scores and winner, go to RUNNING.
- Miss detection, only in RUNNING:
  - Left miss: i_ball_x==0 and ball row not covered by paddle 1.
  - Right miss: i_ball_x==BOARD_WIDTH-1 and ball row not covered by paddle 2.
  - Covered means i_paddle_y ≤ i_ball_y ≤ i_paddle_y+PADDLE_HEIGHT-1. The sum is computed 7 bits wide, so there is no wrap near the bottom edge.
  - A covered ball is a hit; the ball stage bounces it and no action is taken here.
- On a left miss, o_score_p2 increments; on a right miss, o_score_p1 increments. The score register updates in the cycle after detection, together with the state change.
- Point state selection: if the new score equals SCORE_LIMIT, go to GAME_OVER; otherwise go to POINT.
- Latency: o_game_active falls 1 clk after the miss is detected. The ball is then recentred by the ball stage, so the miss cannot re-trigger.
- Scores saturate at SCORE_LIMIT and never wrap.
- Start presses in RUNNING or POINT are ignored.
- Left and right misses cannot coincide (distinct columns). If BOARD_WIDTH==1 by misconfiguration, left-miss has priority.
- Reset mid-game or mid-pause returns to IDLE immediately and clears the scores.

Optional Feature:
- Macro PONG_SERVE_ALTERNATE_EN.
- With it defined:
  - Add output o_serve_dir (1 bit; 0 = serve toward P1, 1 = toward P2).
  - After each point, o_serve_dir is set toward the player who just lost the point.
  - Reset value is 0; o_serve_dir is held constant in RUNNING.
  - The ball stage may use it to choose its initial direction.
- Without it: the port is absent and serve direction is fixed by the ball stage.

Decomposition:
- Shared package pong_pkg holds:
  - state enum encoding (IDLE=0, RUNNING=1, POINT=2, GAME_OVER=3);
  - winner codes;
  - default BOARD_WIDTH/BOARD_HEIGHT/PADDLE_HEIGHT constants, also used by the ball and paddle stages.
- One natural sub-module, pong_paddle_hit: a combinational coverage compare instantiated twice, once per paddle.

Test Plan:
1. Reset, then start press: o_game_active goes to 1 on the 2nd clk after the edge; scores 0/0.
2. Paddle 1 at y=10, ball arrives at x=0,y=12 → no score change, stays RUNNING. Ball at x=0,y=16 → o_score_p2=1, o_game_active=0 for exactly PAUSE_CYCLES (bench uses PAUSE_CYCLES=8), then returns to 1.
3. Paddle 2 at y=27 with PADDLE_HEIGHT=6, ball at x=39,y=31 and y=29 → y=29 is a hit (no wrap); right miss at y=20 → o_score_p1 increments.
4. SCORE_LIMIT=3, three left misses → o_score_p2=3, o_game_over=1, o_winner=10. Holding start gives no restart; release then press → scores 0, RUNNING.
5. Assert i_rst_n=0 mid-POINT with scores 2/1 → all outputs 0 asynchronously, before the next clk edge.
6. With PONG_SERVE_ALTERNATE_EN: P1 misses → o_serve_dir=0. P2 misses next → o_serve_dir=1.
